climate_sensor_averager: RTL and testbench
==========================================

# climate_sensor_averager

Upstream conditioning stage for `climate_prediction`. It accepts raw temperature/pressure samples on a valid strobe and accumulates non-overlapping windows of 2^LOG2_N samples. At the end of each window it presents the averaged values as stable held levels on `temperature`/`pressure`, together with a one-cycle `out_valid` pulse. Partial windows left stale by a sensor dropout are discarded and reported on `timeout`.

## Interface
- `LOG2_N`, default 2: window size is 2^LOG2_N samples. Legal range 0..4.
- `TIMEOUT`, default 16: maximum idle cycles between samples inside a window. Legal range 2..255.
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `sample_valid` input, 1: the raw sample on this cycle is accepted.
- `raw_temp` input, 8: signed two's-complement temperature.
- `raw_press` input, 11: unsigned pressure.
- `temperature` output, 8: signed window average, held. Drives `climate_prediction.temperature`.
- `pressure` output, 11: unsigned window average, held. Drives `climate_prediction.pressure`.
- `out_valid` output, 1: one-cycle pulse when a new average is loaded.
- `primed` output, 1: sticky; set by the first completed window.
- `timeout` output, 1: one-cycle pulse when a partial window is discarded.

## Operation
- Reset values: `temperature`=0, `pressure`=0, `out_valid`=0, `primed`=0, `timeout`=0, both accumulators 0, sample count 0, idle timer 0, state IDLE.
- **FSM states:**
  - IDLE: count = 0, timer disabled.
  - ACCUM: 1 ≤ count ≤ N−1.
- **Transitions:**
  - IDLE + `sample_valid` → ACCUM. When N=1 the window is complete, so emit and stay in IDLE.
  - ACCUM + `sample_valid`, with count+1 < N → ACCUM. Timer clears.
  - ACCUM + `sample_valid`, with count+1 = N → emit, then IDLE.
  - ACCUM, no sample, timer reaches TIMEOUT−1 → discard the partial window, pulse `timeout`, then IDLE.
- **Emit, on the accepting edge:**
  - `temperature` ← (temp_acc + raw_temp) >>> LOG2_N, using an arithmetic shift (floor toward −∞).
  - `pressure` ← (press_acc + raw_press) >> LOG2_N.
  - `out_valid` ← 1, `primed` ← 1.
  - Accumulators and count ← 0.
- **Widths:**
  - temp_acc is signed, 8+LOG2_N bits. raw_temp is sign-extended before the add.
  - press_acc is unsigned, 11+LOG2_N bits.
  - No overflow is possible. Averages always fit their output widths without saturation.
- Outputs hold their values between emits. No other event changes them except reset.
- `timeout` does not alter `temperature`, `pressure` or `primed`.
- **Simultaneous events:**
  - `sample_valid` on the cycle the timer would expire: the sample wins. No timeout is raised and accumulation continues.
  - A sample in IDLE on the same cycle as an emit cannot occur; every accepted sample is counted exactly once.
- Back-to-back windows: the sample that follows an emit edge is accepted as sample 0 of the next window. There is no bubble.
- Reset mid-window: the partial window is lost without a `timeout` pulse. Held outputs return to 0.

## Timing
- Latency: `out_valid` and the new averages appear on the cycle after the edge that accepts the Nth sample. This is a 1-cycle registered latency.
- `out_valid` and `timeout` are each high for exactly one cycle and are never high together.
- Minimum emit spacing: N cycles, with continuous `sample_valid`.
- Timeout fires TIMEOUT cycles after the last accepted sample. The timer counts idle cycles only, and only in ACCUM.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Structure
- **Shared package `climate_pkg`:**
  - `TEMP_W`=8 and `PRESS_W`=11.
  - `avg_state_t` enum {IDLE, ACCUM}.
  - The temperature/pressure typedefs also used by `climate_prediction`.
- **Sub-module `climate_avg_lane`:**
  - Parameters: width, signedness, LOG2_N.
  - Contents: accumulator, clear/add controls and shifted result.
  - Instantiated twice, once for temperature (signed) and once for pressure (unsigned).
- **Top level:** owns the FSM, sample counter, idle timer and output registers.

## Test plan
- Reset: hold `rst_n`=0 with samples toggling. All outputs remain 0. After release, nothing changes until the first sample.
- Snow window (LOG2_N=2): temps 8,8,8,8 and pressures 960,961,962,963 on consecutive cycles. One cycle later `temperature`=8, `pressure`=961, one `out_valid` pulse, `primed`=1.
- Negative floor: temps −3,−3,−2,−2 (sum −10), pressure 970 ×4. `temperature`=−3 (0xFD), `pressure`=970.
- Extremes: temps 127 ×4 then −128 ×4, pressures 2047 ×4. Results are exactly 127, then −128, and 2047, with no wrap.
- Timeout (TIMEOUT=16): two samples, then 16 idle cycles. A single `timeout` pulse, held outputs unchanged. Four fresh samples (20, 1015) then give 20/1015.
- Race and reset: a sample on the exact expiry cycle gives no timeout. Asserting `rst_n` low after 3 samples clears all outputs and discards the window. The next 4 samples (30, 940) give 30/940.

Source files
------------

// File: rtl/climate_pkg.sv
// Shared types for the climate sensor front end and predictor.
// Sample widths, averager FSM states and counter widths.
package climate_pkg;

    localparam int TEMP_W  = 8;
    localparam int PRESS_W = 11;

    // Sample counter covers windows up to 16; idle timer up to 255.
    localparam int CNT_W = 5;
    localparam int TMR_W = 8;

    typedef logic signed [TEMP_W-1:0] temp_t;
    typedef logic        [PRESS_W-1:0] press_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } avg_state_t;

endpackage

// File: rtl/climate_avg_lane.sv
// One accumulate-and-shift averaging lane.
// Result is combinational: (acc + sample) scaled by 2^-LOG2_N.
module climate_avg_lane #(
    parameter int W      = 8,
    parameter bit SIGNED = 1'b1,
    parameter int LOG2_N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         add,
    input  logic [W-1:0] sample,
    output logic [W-1:0] result
);

    localparam int AW = W + LOG2_N;

    logic [AW-1:0] acc;
    logic [AW-1:0] ext;
    logic [AW-1:0] sum;

    generate
        if (SIGNED) begin : g_signed
            assign ext    = AW'($signed(sample));
            assign result = W'($signed(sum) >>> LOG2_N);
        end else begin : g_unsigned
            assign ext    = AW'(sample);
            assign result = W'(sum >> LOG2_N);
        end
    endgenerate

    assign sum = acc + ext;

    // Running window sum; clear wins over add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/climate_sensor_averager.sv
// Windowed averager feeding climate_prediction.
// Emits held averages per 2^LOG2_N samples; drops stale windows.
module climate_sensor_averager
    import climate_pkg::*;
#(
    parameter int LOG2_N  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic [TEMP_W-1:0]  raw_temp,
    input  logic [PRESS_W-1:0] raw_press,
    output logic [TEMP_W-1:0]  temperature,
    output logic [PRESS_W-1:0] pressure,
    output logic               out_valid,
    output logic               primed,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(1 << LOG2_N);
    localparam logic [TMR_W-1:0] T_LAST = TMR_W'(TIMEOUT - 1);

    avg_state_t state;
    avg_state_t state_nxt;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] count_inc;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;

    logic   emit;
    logic   discard;
    logic   add;
    logic   last;
    temp_t  temp_avg;
    press_t press_avg;

    assign count_inc = count + 1'b1;
    assign last      = (count_inc == N_CNT);

    climate_avg_lane #(
        .W      (TEMP_W),
        .SIGNED (1'b1),
        .LOG2_N (LOG2_N)
    ) u_temp_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (emit | discard),
        .add    (add),
        .sample (raw_temp),
        .result (temp_avg)
    );

    climate_avg_lane #(
        .W      (PRESS_W),
        .SIGNED (1'b0),
        .LOG2_N (LOG2_N)
    ) u_press_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (emit | discard),
        .add    (add),
        .sample (raw_press),
        .result (press_avg)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter/timer updates and lane controls.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        timer_nxt = timer;
        emit      = 1'b0;
        discard   = 1'b0;
        add       = 1'b0;
        unique case (state)
            IDLE: begin
                timer_nxt = '0;
                if (sample_valid) begin
                    if (last) begin
                        emit      = 1'b1;
                        count_nxt = '0;
                    end else begin
                        add       = 1'b1;
                        count_nxt = count_inc;
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (sample_valid) begin
                    timer_nxt = '0;
                    if (last) begin
                        emit      = 1'b1;
                        count_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        add       = 1'b1;
                        count_nxt = count_inc;
                    end
                end else if (timer == T_LAST) begin
                    discard   = 1'b1;
                    count_nxt = '0;
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
                timer_nxt = '0;
            end
        endcase
    end

    // Sample counter and idle timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            timer <= '0;
        end else begin
            count <= count_nxt;
            timer <= timer_nxt;
        end
    end

    // Held averages and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temperature <= '0;
            pressure    <= '0;
            out_valid   <= 1'b0;
            primed      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            out_valid <= emit;
            timeout   <= discard;
            if (emit) begin
                temperature <= temp_avg;
                pressure    <= press_avg;
                primed      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_climate_sensor_averager.sv
// Directed bench for climate_sensor_averager.
// Default window of 4 samples, idle timeout of 16 cycles.
module tb_climate_sensor_averager;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [7:0]  raw_temp;
    logic [10:0] raw_press;
    logic [7:0]  temperature;
    logic [10:0] pressure;
    logic        out_valid;
    logic        primed;
    logic        timeout;

    int n_run  = 0;
    int n_fail = 0;

    climate_sensor_averager #(
        .LOG2_N  (2),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .raw_temp     (raw_temp),
        .raw_press    (raw_press),
        .temperature  (temperature),
        .pressure     (pressure),
        .out_valid    (out_valid),
        .primed       (primed),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag,
                        input logic ov, input logic [7:0] t,
                        input logic [10:0] p, input logic pr,
                        input logic to);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".temp"}, 32'(temperature), 32'(t));
        check({tag, ".press"}, 32'(pressure), 32'(p));
        check({tag, ".primed"}, 32'(primed), 32'(pr));
        check({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] t, input logic [10:0] p);
        sample_valid = 1'b1;
        raw_temp     = t;
        raw_press    = p;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        raw_temp     = '0;
        raw_press    = '0;

        for (int i = 0; i < 6; i++) begin
            sample_valid = 1'b1;
            raw_temp     = 8'(i * 9);
            raw_press    = 11'(i * 100 + 3);
            step();
        end
        sample_valid = 1'b0;
        outs("rst_hold", 0, 8'h00, 11'd0, 0, 0);
        rst_n = 1'b1;
        idle(3);
        outs("post_rst", 0, 8'h00, 11'd0, 0, 0);

        push(8'd8, 11'd960);
        push(8'd8, 11'd961);
        push(8'd8, 11'd962);
        check("snow.early", 32'(out_valid), 32'd0);
        push(8'd8, 11'd963);
        outs("snow", 1, 8'd8, 11'd961, 1, 0);
        step();
        outs("snow.hold", 0, 8'd8, 11'd961, 1, 0);

        push(8'hFD, 11'd970);
        push(8'hFD, 11'd970);
        push(8'hFE, 11'd970);
        push(8'hFE, 11'd970);
        outs("neg_floor", 1, 8'hFD, 11'd970, 1, 0);
        step();

        for (int i = 0; i < 4; i++) push(8'd127, 11'd2047);
        outs("max", 1, 8'd127, 11'd2047, 1, 0);
        for (int i = 0; i < 4; i++) push(8'h80, 11'd2047);
        outs("min_b2b", 1, 8'h80, 11'd2047, 1, 0);
        step();

        push(8'd50, 11'd100);
        push(8'd50, 11'd100);
        idle(15);
        check("to.early", 32'(timeout), 32'd0);
        step();
        outs("to.fire", 0, 8'h80, 11'd2047, 1, 1);
        step();
        check("to.pulse", 32'(timeout), 32'd0);
        for (int i = 0; i < 4; i++) push(8'd20, 11'd1015);
        outs("to.fresh", 1, 8'd20, 11'd1015, 1, 0);
        step();

        push(8'd40, 11'd900);
        push(8'd40, 11'd900);
        idle(15);
        push(8'd40, 11'd900);
        check("race.no_to", 32'(timeout), 32'd0);
        check("race.no_ov", 32'(out_valid), 32'd0);
        push(8'd40, 11'd900);
        outs("race.emit", 1, 8'd40, 11'd900, 1, 0);
        step();

        for (int i = 0; i < 3; i++) push(8'd77, 11'd1500);
        #2;
        rst_n = 1'b0;
        #2;
        outs("mid_rst", 0, 8'h00, 11'd0, 0, 0);
        rst_n = 1'b1;
        step();
        push(8'd30, 11'd940);
        check("rst.discard", 32'(out_valid), 32'd0);
        push(8'd30, 11'd940);
        push(8'd30, 11'd940);
        push(8'd30, 11'd940);
        outs("rst.fresh", 1, 8'd30, 11'd940, 1, 0);
        step();
        outs("final", 0, 8'd30, 11'd940, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
